fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RISC-V pipeline: owns the PC register, drives the instruction memory address, and captures the returned instruction into the IF/ID pipeline register.
- Obeys stall/flush from the hazard unit and PC redirects (branch/jump) resolved in EX.
- Instruction memory is combinational and byte-addressed, so `imem_rd` is valid in the same cycle `imem_addr` is driven.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, `addi x0,x0,0`, inserted into IF/ID on bubble/flush.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall_f  in  1  hold PC (hazard unit).
- stall_d  in  1  hold IF/ID register (hazard unit).
- flush_d  in  1  replace IF/ID contents with bubble.
- pc_src_e  in  1  redirect taken (branch taken / jal / jalr), from EX.
- pc_target_e  in  32  redirect target, from EX.
- imem_rd  in  32  instruction word from instruction memory.
- imem_addr  out  32  = pc_f, to instruction memory address.
- pc_f  out  32  current fetch PC.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pcplus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real fetched instruction.

Behaviour:
- Clocking/reset: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset (`rst`=1 at an edge):
  - pc_f=RESET_PC; instr_d=NOP_INSTR; pc_d=0; pcplus4_d=0; valid_d=0.
  - Reset overrides every other input, including mid-stall and mid-redirect.
- Next-PC mux, combinational:
  - pcplus4_f = pc_f + 32'd4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - pc_next = pc_src_e ? {pc_target_e[31:2],2'b00} : pcplus4_f. Target bits [1:0] are forced to 0.
- PC register priority, highest first:
  - rst.
  - pc_src_e: load pc_next, even when stall_f=1.
  - stall_f: hold.
  - otherwise load pcplus4_f.
- IF/ID register priority, highest first:
  - rst.
  - flush_d: load {NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0}. flush_d beats stall_d.
  - stall_d: hold all four fields.
  - otherwise load {imem_rd, pc_f, pcplus4_f, valid_d=1}.
- Latency:
  - Instruction fetched at pc_f in cycle N appears on instr_d in cycle N+1.
  - Redirect asserted in cycle N: pc_f=target in N+1; target instruction appears on instr_d in N+2.
  - The hazard unit is responsible for asserting flush_d in cycle N to kill the wrong-path instruction.
- First cycle after reset release: imem_addr=RESET_PC. valid_d becomes 1 one cycle later.
- imem_addr is never registered separately; it always equals pc_f.
- No X propagation: every output register has a reset value.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: three 32-bit saturating counters with outputs perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt.
  - perf_fetch_cnt increments on each cycle IF/ID loads a valid instruction.
  - perf_stall_cnt increments on each cycle with stall_f=1 and pc_src_e=0.
  - perf_flush_cnt increments on each cycle with flush_d=1.
  - All counters clear on rst and hold at 32'hFFFF_FFFF.
- Undefined: counters and ports are absent; core behaviour is identical.

Decomposition:
- Shared package `riscv_pkg`: XLEN=32, NOP_INSTR constant, RESET_PC constant, and a packed `if_id_t` struct {instr, pc, pcplus4, valid}. The same struct is reused by the decode stage.
- One natural sub-module, `if_id_reg`: IF/ID pipeline register with the flush/stall priority above.
- The PC register and next-PC mux stay in `fetch_stage`.

Test Plan:
- Reset then free run, imem model returns 32'h0062E233 at addr 0 and 32'h01498933 at addr 4:
  - pc_f steps 0, 4, 8.
  - instr_d = 32'h0062E233 then 32'h01498933.
  - valid_d=0 in the first cycle after reset, then 1.
- stall_f=stall_d=1 for 2 cycles at pc_f=8: pc_f stays 8, instr_d/pc_d unchanged; resumes at 12 on release.
- pc_src_e=1 with pc_target_e=32'h0000_0043 at pc_f=12, plus flush_d=1 in the same cycle:
  - next pc_f=32'h40.
  - instr_d=32'h0000_0013 with valid_d=0.
  - the following cycle pc_d=32'h40.
- Simultaneous stall_f=1 and pc_src_e=1 (target 32'h20): pc_f=32'h20 next cycle, i.e. redirect wins.
- Simultaneous stall_d=1 and flush_d=1: IF/ID becomes bubble.
- Wrap and reset priority:
  - pc_f=32'hFFFF_FFFC with no stall: next pc_f=0.
  - rst asserted during a stall: pc_f=RESET_PC and valid_d=0 on the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: word width, reset/bubble constants and the
// IF/ID payload struct that both the fetch and decode stages use.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic            valid;
    } if_id_t;

    // Saturating increment used by the optional performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and flush both insert a bubble, and a flush
// outranks a stall so a killed instruction never lingers in decode.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   stall,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t bubble;

    assign bubble = '{instr: BUBBLE_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= bubble;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC mux and IF/ID capture. Optional performance
// counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_f,
    input  logic                      stall_d,
    input  logic                      flush_d,
    input  logic                      pc_src_e,
    input  logic [riscv_pkg::XLEN-1:0] pc_target_e,
    input  logic [riscv_pkg::XLEN-1:0] imem_rd,
    output logic [riscv_pkg::XLEN-1:0] imem_addr,
    output logic [riscv_pkg::XLEN-1:0] pc_f,
    output logic [riscv_pkg::XLEN-1:0] instr_d,
    output logic [riscv_pkg::XLEN-1:0] pc_d,
    output logic [riscv_pkg::XLEN-1:0] pcplus4_d,
    output logic                      valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetch_cnt,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_flush_cnt
`endif
);

    import riscv_pkg::*;

    logic [XLEN-1:0] pcplus4_f;
    logic [XLEN-1:0] pc_next;
    if_id_t          if_id_in;
    if_id_t          if_id_q;

    // Redirect targets are forced word-aligned; sequential fetch wraps mod 2^32.
    assign pcplus4_f = pc_f + 32'd4;
    assign pc_next   = pc_src_e ? (pc_target_e & ~32'd3) : pcplus4_f;
    assign imem_addr = pc_f;

    // A redirect from EX must land even while the hazard unit stalls fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f <= RESET_PC;
        end else if (pc_src_e || !stall_f) begin
            pc_f <= pc_next;
        end
    end

    assign if_id_in = '{instr: imem_rd, pc: pc_f, pcplus4: pcplus4_f, valid: 1'b1};

    if_id_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_d),
        .stall (stall_d),
        .d     (if_id_in),
        .q     (if_id_q)
    );

    assign instr_d   = if_id_q.instr;
    assign pc_d      = if_id_q.pc;
    assign pcplus4_d = if_id_q.pcplus4;
    assign valid_d   = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    // Fetch count tracks real loads into IF/ID, i.e. neither flushed nor held.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!flush_d && !stall_d) begin
                perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            end
            if (stall_f && !pc_src_e) begin
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            end
            if (flush_d) begin
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
            end
        end
    end
`endif

endmodule
